// File: rtl/stream_demux_pkg.sv
// Shared types, parameter limits and select helper for the stream demultiplexer.
package stream_demux_pkg;

  localparam int N_MIN = 2;
  localparam int N_MAX = 32;
  localparam int W_MIN = 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  function automatic logic sel_ok(input logic [31:0] a, input logic [31:0] n);
    return a < n;
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Producer/consumer bundle for stream_demux; names carry the direction seen by the demux.
interface stream_demux_if #(
  parameter int N = 8,
  parameter int W = 8
) ();
  localparam int AW = $clog2(N);

  logic            i_en;
  logic            i_bcast;
  logic            i_in_valid;
  logic            o_in_ready;
  logic [W-1:0]    i_d;
  logic [AW-1:0]   i_a;
  logic [N*W-1:0]  o_f;
  logic [N-1:0]    o_f_valid;
  logic [N-1:0]    i_f_ready;
  logic            o_err;

  modport master (
    output i_en, i_bcast, i_in_valid, i_d, i_a, i_f_ready,
    input  o_in_ready, o_f, o_f_valid, o_err
  );

  modport slave (
    input  i_en, i_bcast, i_in_valid, i_d, i_a, i_f_ready,
    output o_in_ready, o_f, o_f_valid, o_err
  );
endinterface

// File: rtl/stream_demux_slot.sv
// One-entry output register for a single demux channel; data reads zero while empty.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_free
);

  slot_state_e  r_state;
  logic [W-1:0] r_data;

  // Load has priority over drain so a same-cycle refill keeps the slot full.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= EMPTY;
      r_data  <= '0;
    end else if (i_load) begin
      r_state <= FULL;
      r_data  <= i_d;
    end else if (r_state == FULL && i_ready) begin
      r_state <= EMPTY;
      r_data  <= '0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = (r_state == FULL);
  assign o_free  = (r_state == EMPTY) || i_ready;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with broadcast and sticky out-of-range error.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  stream_demux_if.slave  bus
);

  if (N < N_MIN || N > N_MAX || W < W_MIN) begin : g_param_check
    $error("stream_demux: N or W out of range");
  end

  logic [N-1:0] w_free;
  logic [N-1:0] w_hit;
  logic [N-1:0] w_load;
  logic         w_sel_ok;
  logic         w_sel_free;
  logic         w_all_free;
  logic         w_in_ready;
  logic         w_accept;
  logic         r_err;

  assign w_sel_ok   = sel_ok(32'(bus.i_a), 32'(N));
  assign w_sel_free = |(w_hit & w_free);
  assign w_all_free = &w_free;

  // An out-of-range select is always accepted so the word can be dropped.
  assign w_in_ready = !bus.i_en && (bus.i_bcast ? w_all_free : (!w_sel_ok || w_sel_free));
  assign w_accept   = bus.i_in_valid && w_in_ready;
  assign w_load     = w_accept ? (bus.i_bcast ? {N{1'b1}} : w_hit) : '0;

  genvar k;
  for (k = 0; k < N; k++) begin : g_slot
    assign w_hit[k] = (32'(bus.i_a) == 32'(k));

    demux_slot #(.W(W)) u_slot (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_load[k]),
      .i_d     (bus.i_d),
      .i_ready (bus.i_f_ready[k]),
      .o_data  (bus.o_f[k*W +: W]),
      .o_valid (bus.o_f_valid[k]),
      .o_free  (w_free[k])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (w_accept && !bus.i_bcast && !w_sel_ok) begin
      r_err <= 1'b1;
    end
  end

  assign bus.o_in_ready = w_in_ready;
  assign bus.o_err      = r_err;

endmodule
